// File: rtl/uart_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// uart_pkg - shared constants and state type for the UART rx control
// Rev 1.0
// ------------------------------------------------------------------
package uart_pkg;

  localparam int DEF_DATA_W = 8;

  localparam logic [1:0] ST_DISABLED = 2'd0;
  localparam logic [1:0] ST_RUN      = 2'd1;
  localparam logic [1:0] ST_ERR_HOLD = 2'd2;

  typedef enum logic [1:0] {
    S_DISABLED = ST_DISABLED,
    S_RUN      = ST_RUN,
    S_ERR_HOLD = ST_ERR_HOLD
  } state_t;

endpackage
`default_nettype wire

// File: rtl/uart_rx_ctrl_if.sv
`default_nettype none
// ------------------------------------------------------------------
// uart_rx_ctrl_if - receiver-frame input and byte-stream output bundle
// Rev 1.0
// ------------------------------------------------------------------
interface uart_rx_ctrl_if
  import uart_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) ();

  logic              rx_done;
  logic [DATA_W-1:0] rx_data;
  logic              p_error;
  logic              stop_error;
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_ready;

  modport master (
    output rx_done, rx_data, p_error, stop_error, m_ready,
    input  m_valid, m_data
  );

  modport slave (
    input  rx_done, rx_data, p_error, stop_error, m_ready,
    output m_valid, m_data
  );

endinterface
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// ------------------------------------------------------------------
// uart_sync_fifo - single-clock FIFO with a registered head-of-queue output
// Rev 1.0
// ------------------------------------------------------------------
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic                    pop,
  input  logic [DATA_W-1:0]       wr_data,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic [DATA_W-1:0]       rd_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic [DATA_W-1:0] r_rd_data;

  logic              w_push;
  logic              w_pop;
  logic [AW-1:0]     w_rd_ptr_nxt;
  logic [CW-1:0]     w_remain;

  assign full  = (r_count == CW'(DEPTH));
  assign empty = (r_count == '0);

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign w_push       = push & (~full | pop);
  assign w_pop        = pop & ~empty;
  assign w_rd_ptr_nxt = w_pop ? r_rd_ptr + AW'(1) : r_rd_ptr;
  assign w_remain     = r_count - CW'(w_pop);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_rd_data <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      r_rd_ptr <= w_rd_ptr_nxt;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      // Head register: surviving entry if any, otherwise the byte arriving now.
      if (w_remain != '0) begin
        r_rd_data <= r_mem[w_rd_ptr_nxt];
      end else if (w_push) begin
        r_rd_data <= wr_data;
      end
    end
  end

  assign count   = r_count;
  assign rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// uart_rx_ctrl - qualifies received frames, buffers bytes, tracks status
// Rev 1.0
// ------------------------------------------------------------------
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   drop_on_err,
  input  logic                   clr_status,
  uart_rx_ctrl_if.slave          bus,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overrun,
  output logic [CNT_W-1:0]       err_cnt,
  output logic [1:0]             state
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_overrun;
  logic [CNT_W-1:0]  r_err_cnt;

  logic              w_in_run;
  logic              w_flagged;
  logic              w_push_req;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic              w_overrun_evt;
  logic [DATA_W-1:0] w_rd_data;

  assign w_in_run      = (r_state == S_RUN);
  assign w_flagged     = bus.rx_done & (bus.p_error | bus.stop_error);
  assign w_push_req    = bus.rx_done & w_in_run & ~(w_flagged & drop_on_err);
  assign w_pop         = ~w_empty & bus.m_ready;
  assign w_overrun_evt = w_push_req & w_full & ~w_pop;

  uart_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (w_push_req),
    .pop     (w_pop),
    .wr_data (bus.rx_data),
    .full    (w_full),
    .empty   (w_empty),
    .count   (fifo_count),
    .rd_data (w_rd_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_DISABLED;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_DISABLED: begin
        if (enable) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (w_overrun_evt)  w_state_nxt = S_ERR_HOLD;
        else if (!enable)   w_state_nxt = S_DISABLED;
      end
      S_ERR_HOLD: begin
        if (clr_status) w_state_nxt = enable ? S_RUN : S_DISABLED;
      end
      default: w_state_nxt = S_DISABLED;
    endcase
  end

  // Clear wins over a same-cycle set or increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_overrun <= 1'b0;
      r_err_cnt <= '0;
    end else if (clr_status) begin
      r_overrun <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      if (w_overrun_evt) begin
        r_overrun <= 1'b1;
      end
      if (w_flagged && w_in_run && (r_err_cnt != {CNT_W{1'b1}})) begin
        r_err_cnt <= r_err_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.m_valid = ~w_empty;
  assign bus.m_data  = w_rd_data;
  assign overrun     = r_overrun;
  assign err_cnt     = r_err_cnt;
  assign state       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_uart_rx_ctrl - directed vector bench for the UART receive controller
// Rev 1.0
// ------------------------------------------------------------------
module tb_uart_rx_ctrl;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       drop_on_err;
  logic       clr_status;
  logic [3:0] fifo_count;
  logic       overrun;
  logic [7:0] err_cnt;
  logic [1:0] state;
  logic [3:0] fifo_count2;
  logic       overrun2;
  logic [1:0] err_cnt2;
  logic [1:0] state2;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       rx_done;
    logic [7:0] data;
    logic       pe;
    logic       se;
    logic       drop;
    logic       rdy;
    logic       exp_valid;
    logic [7:0] exp_data;
    int         exp_count;
    int         exp_err;
  } vec_t;

  vec_t vecs[15];

  uart_rx_ctrl_if #(.DATA_W(8)) rx_if ();
  uart_rx_ctrl_if #(.DATA_W(8)) rx_if2 ();

  uart_rx_ctrl #(.DATA_W(8), .DEPTH(8), .CNT_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .drop_on_err (drop_on_err),
    .clr_status  (clr_status),
    .bus         (rx_if),
    .fifo_count  (fifo_count),
    .overrun     (overrun),
    .err_cnt     (err_cnt),
    .state       (state)
  );

  uart_rx_ctrl #(.DATA_W(8), .DEPTH(8), .CNT_W(2)) dut2 (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .drop_on_err (drop_on_err),
    .clr_status  (clr_status),
    .bus         (rx_if2),
    .fifo_count  (fifo_count2),
    .overrun     (overrun2),
    .err_cnt     (err_cnt2),
    .state       (state2)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic pe, input logic se);
    rx_if.rx_done    = 1'b1;
    rx_if.rx_data    = d;
    rx_if.p_error    = pe;
    rx_if.stop_error = se;
    tick();
    rx_if.rx_done    = 1'b0;
    rx_if.p_error    = 1'b0;
    rx_if.stop_error = 1'b0;
  endtask

  task automatic drain(input logic [7:0] first, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_valid%0d", tag, i), 32'(rx_if.m_valid), 32'd1);
      check($sformatf("%s_data%0d", tag, i), 32'(rx_if.m_data), 32'(first) + 32'(i));
      rx_if.m_ready = 1'b1;
      tick();
      rx_if.m_ready = 1'b0;
    end
    check($sformatf("%s_empty", tag), 32'(fifo_count), 32'd0);
  endtask

  initial begin
    // rx_done, data, pe, se, drop, rdy | valid, data, count, err_cnt
    vecs[0]  = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h55, 1, 0};
    vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 0, 0};
    vecs[2]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 0, 1};
    vecs[3]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h3C, 1, 1};
    vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 0, 1};
    vecs[5]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 1, 2};
    vecs[6]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h3C, 1, 2};
    vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 0, 2};
    vecs[8]  = '{1'b1, 8'h81, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h81, 1, 3};
    vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 0, 3};
    vecs[10] = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 1, 3};
    vecs[11] = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 2, 3};
    vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h22, 1, 3};
    vecs[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 0, 3};
    vecs[14] = '{1'b1, 8'h5A, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 0, 4};

    reset             = 1'b0;
    enable            = 1'b0;
    drop_on_err       = 1'b0;
    clr_status        = 1'b0;
    rx_if.rx_done     = 1'b0;
    rx_if.rx_data     = 8'h00;
    rx_if.p_error     = 1'b0;
    rx_if.stop_error  = 1'b0;
    rx_if.m_ready     = 1'b0;
    rx_if2.rx_done    = 1'b0;
    rx_if2.rx_data    = 8'h00;
    rx_if2.p_error    = 1'b0;
    rx_if2.stop_error = 1'b0;
    rx_if2.m_ready    = 1'b1;

    tick();
    tick();
    check("rst_valid",   32'(rx_if.m_valid), 32'd0);
    check("rst_data",    32'(rx_if.m_data),  32'd0);
    check("rst_count",   32'(fifo_count),    32'd0);
    check("rst_overrun", 32'(overrun),       32'd0);
    check("rst_errcnt",  32'(err_cnt),       32'd0);
    check("rst_state",   32'(state),         32'(ST_DISABLED));

    reset  = 1'b1;
    enable = 1'b1;
    tick();
    check("enable_state", 32'(state), 32'(ST_RUN));

    // Single-frame delivery, error filtering and stream back-pressure
    for (int i = 0; i < 15; i++) begin
      rx_if.rx_done    = vecs[i].rx_done;
      rx_if.rx_data    = vecs[i].data;
      rx_if.p_error    = vecs[i].pe;
      rx_if.stop_error = vecs[i].se;
      drop_on_err      = vecs[i].drop;
      rx_if.m_ready    = vecs[i].rdy;
      tick();
      check($sformatf("vec%0d_valid", i), 32'(rx_if.m_valid), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) begin
        check($sformatf("vec%0d_data", i), 32'(rx_if.m_data), 32'(vecs[i].exp_data));
      end
      check($sformatf("vec%0d_count", i), 32'(fifo_count), 32'(vecs[i].exp_count));
      check($sformatf("vec%0d_errcnt", i), 32'(err_cnt), 32'(vecs[i].exp_err));
    end
    rx_if.rx_done    = 1'b0;
    rx_if.p_error    = 1'b0;
    rx_if.stop_error = 1'b0;
    rx_if.m_ready    = 1'b0;
    drop_on_err      = 1'b0;

    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    check("clr_run_errcnt", 32'(err_cnt), 32'd0);
    check("clr_run_state",  32'(state),   32'(ST_RUN));

    // Fill past capacity, then a frame while held
    for (int i = 1; i <= 8; i++) send(8'(i), 1'b0, 1'b0);
    check("fill_count",   32'(fifo_count), 32'd8);
    check("fill_overrun", 32'(overrun),    32'd0);
    send(8'h09, 1'b0, 1'b0);
    check("ovr_overrun", 32'(overrun),    32'd1);
    check("ovr_state",   32'(state),      32'(ST_ERR_HOLD));
    check("ovr_count",   32'(fifo_count), 32'd8);
    send(8'h0A, 1'b1, 1'b0);
    check("hold_count",  32'(fifo_count), 32'd8);
    check("hold_errcnt", 32'(err_cnt),    32'd0);
    drain(8'h01, 8, "ovr_drain");
    check("drain_state", 32'(state), 32'(ST_ERR_HOLD));

    // ERR_HOLD ignores enable; clr_status recovers
    enable = 1'b0;
    tick();
    check("hold_noenable", 32'(state), 32'(ST_ERR_HOLD));
    enable     = 1'b1;
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    check("recover_state",   32'(state),   32'(ST_RUN));
    check("recover_overrun", 32'(overrun), 32'd0);
    check("recover_errcnt",  32'(err_cnt), 32'd0);
    send(8'h77, 1'b0, 1'b0);
    check("recover_valid", 32'(rx_if.m_valid), 32'd1);
    check("recover_data",  32'(rx_if.m_data),  32'h77);
    drop_on_err = 1'b1;
    send(8'hEE, 1'b1, 1'b0);
    check("flag_errcnt", 32'(err_cnt),    32'd1);
    check("flag_count",  32'(fifo_count), 32'd1);
    clr_status = 1'b1;
    send(8'hEF, 1'b1, 1'b0);
    clr_status = 1'b0;
    check("clr_prio_errcnt", 32'(err_cnt), 32'd0);
    drop_on_err   = 1'b0;
    rx_if.m_ready = 1'b1;
    tick();
    rx_if.m_ready = 1'b0;
    check("pop77_count", 32'(fifo_count), 32'd0);

    // Full FIFO with simultaneous push and pop
    for (int i = 0; i < 8; i++) send(8'h21 + 8'(i), 1'b0, 1'b0);
    check("full_count", 32'(fifo_count), 32'd8);
    rx_if.m_ready = 1'b1;
    send(8'h29, 1'b0, 1'b0);
    rx_if.m_ready = 1'b0;
    check("pp_count",   32'(fifo_count), 32'd8);
    check("pp_overrun", 32'(overrun),    32'd0);
    check("pp_state",   32'(state),      32'(ST_RUN));
    drain(8'h22, 8, "pp_drain");

    // Asynchronous reset discards buffered data
    for (int i = 0; i < 3; i++) send(8'h31 + 8'(i), 1'b0, 1'b0);
    check("pre_rst_count", 32'(fifo_count), 32'd3);
    #2;
    reset = 1'b0;
    #1;
    check("async_valid", 32'(rx_if.m_valid), 32'd0);
    check("async_count", 32'(fifo_count),    32'd0);
    check("async_state", 32'(state),         32'(ST_DISABLED));
    tick();
    reset = 1'b1;
    tick();
    check("post_rst_state", 32'(state), 32'(ST_RUN));
    check("post_rst_valid", 32'(rx_if.m_valid), 32'd0);

    // Saturating error counter on the narrow instance
    drop_on_err = 1'b1;
    for (int k = 0; k < 5; k++) begin
      rx_if2.rx_done = 1'b1;
      rx_if2.rx_data = 8'hC0 + 8'(k);
      rx_if2.p_error = 1'b1;
      tick();
      rx_if2.rx_done = 1'b0;
      rx_if2.p_error = 1'b0;
      check($sformatf("sat_errcnt%0d", k), 32'(err_cnt2), (k < 3) ? 32'(k + 1) : 32'd3);
    end
    check("sat_count", 32'(fifo_count2), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Receive-side controller between the UART receiver datapath (top_rx) and the byte consumer. It qualifies each completed frame against its parity and stop error flags, buffers accepted bytes in a small FIFO, and presents them on a valid/ready stream. It sequences enable, overrun-hold and recovery, and keeps sticky status and an error counter for software.

Parameters:
DATA_W, 8, data byte width; matches the receiver d_out.
DEPTH, 8, FIFO entries; must be a power of 2 and at least 2.
CNT_W, 8, width of the saturating frame-error counter.

Ports:
clk  in  1  system clock, same domain as the receiver.
reset  in  1  asynchronous, active-low reset.
enable  in  1  level; 1 means accept frames from the receiver.
drop_on_err  in  1  level; 1 means discard frames flagged with a parity or stop error.
clr_status  in  1  one-cycle pulse; clears overrun and err_cnt and exits ERR_HOLD.
rx_done  in  1  one-cycle strobe from the receiver: frame complete, rx_data and flags valid.
rx_data  in  DATA_W  received byte (receiver d_out).
p_error  in  1  parity error for the current frame; sampled only with rx_done.
stop_error  in  1  stop-bit error for the current frame; sampled only with rx_done.
m_valid  out  1  FIFO head byte available.
m_data  out  DATA_W  FIFO head byte.
m_ready  in  1  consumer accepts the head byte.
fifo_count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
overrun  out  1  sticky; a frame was lost because the FIFO was full.
err_cnt  out  CNT_W  count of flagged frames; saturates at all-ones.
state  out  2  current FSM state, for debug.

Behaviour:
- Reset (reset=0, asynchronous): state=DISABLED; FIFO pointers and fifo_count=0; m_valid=0; m_data=0; overrun=0; err_cnt=0. Asserting reset mid-operation discards all buffered data.
- State encoding: DISABLED=0, RUN=1, ERR_HOLD=2. Encoding 3 is illegal and recovers to DISABLED.
- Transitions:
  - DISABLED -> RUN when enable=1.
  - RUN -> DISABLED when enable=0.
  - RUN -> ERR_HOLD on an overrun event.
  - ERR_HOLD -> RUN on clr_status with enable=1.
  - ERR_HOLD -> DISABLED on clr_status with enable=0.
  - ERR_HOLD is unaffected by enable until clr_status arrives.
- Flagged frame: rx_done=1 with (p_error | stop_error)=1.
- Push request: rx_done=1 in RUN, and not (flagged and drop_on_err=1). rx_done in DISABLED or ERR_HOLD is ignored entirely: no push and no count.
- Pop: m_valid & m_ready.
- Push when FIFO not full: rx_data is written and fifo_count increments.
- Push when full with no pop in the same cycle: byte dropped, overrun<=1, next state ERR_HOLD.
- Push when full with a pop in the same cycle: push accepted, fifo_count unchanged, no overrun.
- Push and pop in the same cycle when not empty: both happen, fifo_count unchanged.
- Pop on empty cannot occur, since m_valid=0 when empty.
- Latency: a byte pushed at clock edge N appears with m_valid=1 after edge N; no combinational fall-through from rx_data to m_data.
- m_data and m_valid stay stable while m_valid=1 and m_ready=0.
- Pointers wrap modulo DEPTH. full means fifo_count==DEPTH; empty means fifo_count==0.
- The consumer may keep draining in every state, including DISABLED and ERR_HOLD.
- err_cnt increments by 1 for each flagged frame seen in RUN, whether or not it is dropped. It saturates at 2^CNT_W-1.
- clr_status has priority over a same-cycle increment or overrun set: the result is cleared.
- Frames with a stop error are otherwise handled identically to frames with a parity error.

Decomposition:
- Shared package uart_pkg:
  - state localparams ST_DISABLED, ST_RUN, ST_ERR_HOLD;
  - DATA_W default constant.
- One sub-module, uart_sync_fifo (parameters DATA_W, DEPTH), with push, pop, full, empty, count and registered read data.
- The FSM, frame qualification and status logic stay in uart_rx_ctrl.

Test Plan:
1. Reset held, then released with enable=1. Drive rx_done with 0x55, no error flags, m_ready=1 -> m_valid=1 one cycle later with m_data=0x55, then fifo_count returns to 0 and err_cnt=0.
2. drop_on_err=1. Send 0xA5 with p_error=1, then 0x3C clean -> only 0x3C is delivered and err_cnt=1. Repeat with drop_on_err=0 -> both bytes delivered and err_cnt=2.
3. m_ready=0. Send 9 frames 0x01..0x09 with DEPTH=8 -> fifo_count=8, overrun=1, state=ERR_HOLD. A 10th frame is ignored. Drain -> 0x01..0x08 in order.
4. FIFO full. Push and pop in the same cycle -> no overrun, fifo_count stays 8, and the new byte arrives last in order.
5. In ERR_HOLD, pulse clr_status with enable=1 -> overrun=0, err_cnt=0, state=RUN, and the next frame is accepted. Also assert clr_status in the same cycle as a flagged frame -> err_cnt=0.
6. Load 3 bytes, then assert reset for 1 cycle -> m_valid=0 and fifo_count=0 immediately (asynchronously). With CNT_W=2, 5 flagged frames -> err_cnt saturates at 3.
